// File: rtl/dual_prio_enc_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dual_prio_enc_pkg
//  Purpose  : Shared types/helpers for the dual-priority encoder pipeline.
//             idx_width()       - index width for an N-bit request vector
//             popcount()        - number of set bits (up to 64 bits)
//             onehot_from_idx() - 1-based index to one-hot mask, 0 -> empty
//             IDX_NONE          - index value meaning "no request"
//  Revision : 1.0 - initial release
// ============================================================================
package dual_prio_enc_pkg;

    localparam int IDX_NONE = 0;

    function automatic int idx_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0]  cnt;
        logic [63:0] t;
        cnt = '0;
        t   = v;
        for (int k = 0; k < 64; k++) begin
            cnt = cnt + {6'd0, t[0]};
            t   = t >> 1;
        end
        return cnt;
    endfunction

    // Indices outside 1..n produce an empty mask so callers never clear a
    // bit that does not exist in their request vector.
    function automatic logic [63:0] onehot_from_idx(input logic [6:0] idx, input int n);
        if (idx == 7'd0 || int'(idx) > n) begin
            return 64'd0;
        end
        return 64'd1 << (idx - 7'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_prio_enc_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : dual_prio_enc_pipe_if
//  Purpose  : Valid/ready stream bundle for the dual-priority encoder.
//             master : request producer / result consumer side
//             slave  : encoder side
//  Signals  : in_valid, in_ready, in_req[N], out_valid, out_ready,
//             out_first[IW], out_second[IW], out_count[IW]
//  Revision : 1.0 - initial release
// ============================================================================
interface dual_prio_enc_pipe_if
    import dual_prio_enc_pkg::*;
#(
    parameter int N = 12
);
    localparam int IW = idx_width(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_req;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_first;
    logic [IW-1:0] out_second;
    logic [IW-1:0] out_count;

    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_first, out_second, out_count
    );

    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_first, out_second, out_count
    );

endinterface
`default_nettype wire

// File: rtl/dual_prio_enc_pipe_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : dpe_prio_enc
//  Purpose  : Combinational priority encoder with a rotating start point.
//             Search starts at bit base-1, goes downward and wraps from bit 0
//             to bit N-1. base == N gives plain highest-bit-wins priority.
//  Ports    : req[N]  request vector (bit k = request k+1)
//             base    search start (1..N)
//             idx     1-based winning index, 0 = none
//  Revision : 1.0 - initial release
// ============================================================================
module dpe_prio_enc
    import dual_prio_enc_pkg::*;
#(
    parameter int N = 12,
    localparam int IW = idx_width(N)
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [IW-1:0] base,
    output logic      [IW-1:0] idx
);

    logic [N-1:0] w_below;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_sel;
    logic [N-1:0] w_sh;

    // Bits below base outrank every bit at or above base, so the wrapped
    // search reduces to "highest set bit of the below-base group if any,
    // otherwise highest set bit overall".
    always_comb begin
        w_below  = ~({N{1'b1}} << base);
        w_masked = req & w_below;
        w_sel    = (|w_masked) ? w_masked : req;
        idx      = IW'(IDX_NONE);
        w_sh     = w_sel;
        for (int j = 0; j < N; j++) begin
            if (w_sh[0]) begin
                idx = IW'(j + 1);
            end
            w_sh = w_sh >> 1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dual_prio_enc_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : dual_prio_enc_pipe
//  Purpose  : Two-stage pipelined dual-priority encoder, valid/ready stream.
//             S1 registers req, first index and popcount; S2 computes the
//             second index and loads the output registers.
//  Ports    : clk    rising-edge clock
//             rst_n  asynchronous active-low reset
//             bus    dual_prio_enc_pipe_if.slave (in_valid/in_ready/in_req,
//                    out_valid/out_ready/out_first/out_second/out_count)
//  Config   : DUAL_PRIO_ENC_ROTATE_EN - rotating priority pointer; the last
//             granted request becomes lowest priority.
//  Revision : 1.0 - initial release
// ============================================================================
module dual_prio_enc_pipe
    import dual_prio_enc_pkg::*;
#(
    parameter int N = 12
) (
    input wire logic           clk,
    input wire logic           rst_n,
    dual_prio_enc_pipe_if.slave bus
);

    localparam int IW = idx_width(N);

    logic          w_s2_adv;
    logic          w_in_ready;
    logic          w_in_fire;
    logic [IW-1:0] w_base;
    logic [IW-1:0] w_s2_base;
    logic [IW-1:0] w_first;
    logic [IW-1:0] w_second;
    logic [IW-1:0] w_count;
    logic [N-1:0]  w_s2_req;

    logic          r_s1_valid;
    logic [N-1:0]  r_s1_req;
    logic [IW-1:0] r_s1_first;
    logic [IW-1:0] r_s1_count;
    logic          r_out_valid;
    logic [IW-1:0] r_out_first;
    logic [IW-1:0] r_out_second;
    logic [IW-1:0] r_out_count;

    // in_ready looks only at pipeline state and out_ready, never in_valid.
    assign w_s2_adv   = !r_out_valid || bus.out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_count    = IW'(popcount(64'(bus.in_req)));

`ifdef DUAL_PRIO_ENC_ROTATE_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_s1_base;

    // The pointer moves to just below the granted bit, so that request is
    // searched last next time; first == 1 wraps the start back to bit N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N);
        end else if (w_in_fire && w_first != IW'(IDX_NONE)) begin
            r_ptr <= (w_first == IW'(1)) ? IW'(N) : (w_first - IW'(1));
        end
    end

    // S2 must search with the same start point S1 used for this vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_base <= IW'(N);
        end else if (w_in_fire) begin
            r_s1_base <= r_ptr;
        end
    end

    assign w_base    = r_ptr;
    assign w_s2_base = r_s1_base;
`else
    assign w_base    = IW'(N);
    assign w_s2_base = IW'(N);
`endif

    dpe_prio_enc #(.N(N)) u_enc_first (
        .req  (bus.in_req),
        .base (w_base),
        .idx  (w_first)
    );

    assign w_s2_req = r_s1_req & ~N'(onehot_from_idx(7'(r_s1_first), N));

    dpe_prio_enc #(.N(N)) u_enc_second (
        .req  (w_s2_req),
        .base (w_s2_base),
        .idx  (w_second)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_req   <= '0;
            r_s1_first <= IW'(IDX_NONE);
            r_s1_count <= '0;
        end else if (w_in_ready) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_req   <= bus.in_req;
                r_s1_first <= w_first;
                r_s1_count <= w_count;
            end
        end
    end

    // Output register reloads whenever it empties or is consumed, which
    // gives full throughput when both ends transfer in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_first  <= IW'(IDX_NONE);
            r_out_second <= IW'(IDX_NONE);
            r_out_count  <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_first  <= r_s1_first;
                r_out_second <= w_second;
                r_out_count  <= r_s1_count;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_first  = r_out_first;
    assign bus.out_second = r_out_second;
    assign bus.out_count  = r_out_count;

endmodule
`default_nettype wire
